// File: rtl/d_mem_bram.sv
// Single-port CPU data memory on an inferred block RAM with a d_req/d_ack handshake.
// Optional post-reset zero-fill sweep is compiled in when D_MEM_CLEAR_EN is defined.
`ifndef DIRECTION_WRITE
`define DIRECTION_WRITE 1'b1
`endif

module d_mem_bram #(
  parameter int d_addr_width  = 8,
  parameter int d_data_width  = 8,
  parameter int d_mem_length  = 256,
  parameter int d_wait_states = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    d_req,
  input  logic                    d_dir,
  input  logic [d_addr_width-1:0] d_addr,
  input  logic [d_data_width-1:0] d_wdata,
  output logic                    d_ack,
  output logic [d_data_width-1:0] d_rdata,
  output logic                    busy
);

  localparam int IDX_W = (d_mem_length > 1) ? $clog2(d_mem_length) : 1;
  localparam logic [3:0] WAIT_INIT = (d_wait_states > 0) ? 4'(d_wait_states - 1) : 4'd0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(d_mem_length - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

`ifdef D_MEM_CLEAR_EN
  localparam state_t RESET_STATE = S_CLEAR;
  localparam logic   RESET_BUSY  = 1'b1;
  logic [IDX_W-1:0] clr_addr_q, clr_addr_d;
`else
  localparam state_t RESET_STATE = S_IDLE;
  localparam logic   RESET_BUSY  = 1'b0;
`endif

  logic [d_data_width-1:0] mem_q [0:d_mem_length-1];

  state_t                  state_q, state_d;
  logic [3:0]              wcnt_q, wcnt_d;
  logic                    ack_q;
  logic                    busy_q;
  logic [d_data_width-1:0] rdata_q;

  logic                    in_range_s;
  logic                    is_write_s;
  logic                    mem_we_s;
  logic [IDX_W-1:0]        mem_waddr_s;
  logic [d_data_width-1:0] mem_wdata_s;
  logic                    rd_en_s;

  assign in_range_s = (32'(d_addr) < d_mem_length);
  assign is_write_s = (d_dir == `DIRECTION_WRITE);

  // Next-state logic and RAM port control.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = d_addr[IDX_W-1:0];
    mem_wdata_s = d_wdata;
    rd_en_s     = 1'b0;
`ifdef D_MEM_CLEAR_EN
    clr_addr_d  = clr_addr_q;
`endif
    case (state_q)
`ifdef D_MEM_CLEAR_EN
      S_CLEAR: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = clr_addr_q;
        mem_wdata_s = {d_data_width{1'b0}};
        if (clr_addr_q == LAST_IDX) begin
          state_d = S_IDLE;
        end else begin
          clr_addr_d = clr_addr_q + IDX_W'(1);
        end
      end
`endif
      S_IDLE: begin
        if (d_req) begin
          // Out-of-range writes are acknowledged but never reach the array.
          mem_we_s = is_write_s && in_range_s;
          rd_en_s  = !is_write_s;
          if (d_wait_states > 0) begin
            state_d = S_WAIT;
            wcnt_d  = WAIT_INIT;
          end else begin
            state_d = S_ACK;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (wcnt_q == 4'd0) begin
          state_d = S_ACK;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control registers; ack and busy are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RESET_STATE;
      wcnt_q     <= 4'd0;
      ack_q      <= 1'b0;
      busy_q     <= RESET_BUSY;
      rdata_q    <= {d_data_width{1'b0}};
`ifdef D_MEM_CLEAR_EN
      clr_addr_q <= {IDX_W{1'b0}};
`endif
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      ack_q      <= (state_d == S_ACK);
      busy_q     <= (state_d == S_CLEAR);
`ifdef D_MEM_CLEAR_EN
      clr_addr_q <= clr_addr_d;
`endif
      if (rd_en_s) begin
        rdata_q <= in_range_s ? mem_q[d_addr[IDX_W-1:0]] : {d_data_width{1'b0}};
      end else begin
        rdata_q <= rdata_q;
      end
    end
  end

  // RAM write port; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign d_ack   = ack_q;
  assign d_rdata = rdata_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_d_mem_bram.sv
// Directed bench for d_mem_bram: one zero-wait instance (200 cells) and one
// three-wait-state instance (64 cells); the clear test builds with D_MEM_CLEAR_EN.
module tb_d_mem_bram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_req, a_dir, a_ack, a_busy;
  logic [7:0] a_addr, a_wdata, a_rdata;
  logic       b_rst, b_req, b_dir, b_ack, b_busy;
  logic [7:0] b_addr, b_wdata, b_rdata;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef D_MEM_CLEAR_EN
  localparam logic CLR = 1'b1;
`else
  localparam logic CLR = 1'b0;
`endif

  d_mem_bram #(.d_addr_width(8), .d_data_width(8), .d_mem_length(200), .d_wait_states(0)) u_a (
    .clk(clk), .rst(a_rst), .d_req(a_req), .d_dir(a_dir), .d_addr(a_addr),
    .d_wdata(a_wdata), .d_ack(a_ack), .d_rdata(a_rdata), .busy(a_busy)
  );

  d_mem_bram #(.d_addr_width(8), .d_data_width(8), .d_mem_length(64), .d_wait_states(3)) u_b (
    .clk(clk), .rst(b_rst), .d_req(b_req), .d_dir(b_dir), .d_addr(b_addr),
    .d_wdata(b_wdata), .d_ack(b_ack), .d_rdata(b_rdata), .busy(b_busy)
  );

  // Called at a negedge; returns negedges until ack (0 on timeout) and ack one cycle later.
  task automatic a_xfer(input logic dir, input logic [7:0] addr, input logic [7:0] wd,
                        output int lat, output logic [7:0] rd, output logic ack_after);
    a_req = 1'b1; a_dir = dir; a_addr = addr; a_wdata = wd;
    lat = 0; rd = 8'h00;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (a_ack === 1'b1) begin lat = i; rd = a_rdata; break; end
    end
    a_req = 1'b0;
    @(negedge clk);
    ack_after = a_ack;
  endtask

  task automatic b_xfer(input logic dir, input logic [7:0] addr, input logic [7:0] wd,
                        output int lat, output logic [7:0] rd, output logic ack_after);
    b_req = 1'b1; b_dir = dir; b_addr = addr; b_wdata = wd;
    lat = 0; rd = 8'h00;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (b_ack === 1'b1) begin lat = i; rd = b_rdata; break; end
    end
    b_req = 1'b0;
    @(negedge clk);
    ack_after = b_ack;
  endtask

  task automatic test_reset();
    int waited;
    a_rst = 1'b1; b_rst = 1'b1;
    a_req = 1'b0; a_dir = 1'b0; a_addr = 8'h00; a_wdata = 8'h00;
    b_req = 1'b0; b_dir = 1'b0; b_addr = 8'h00; b_wdata = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (a_ack !== 1'b0 || b_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: a=%b b=%b required 0", a_ack, b_ack); end
    n_cmp++; if (a_rdata !== 8'h00 || b_rdata !== 8'h00) begin n_bad++; $display("FAIL reset_rdata: a=%h b=%h required 00", a_rdata, b_rdata); end
    n_cmp++; if (a_busy !== CLR || b_busy !== CLR) begin n_bad++; $display("FAIL reset_busy: a=%b b=%b required %b", a_busy, b_busy, CLR); end
    a_rst = 1'b0; b_rst = 1'b0;
    waited = 0;
    while ((a_busy !== 1'b0 || b_busy !== 1'b0) && waited < 400) begin @(negedge clk); waited++; end
    n_cmp++; if (a_busy !== 1'b0 || b_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy_release: a=%b b=%b required 0", a_busy, b_busy); end
  endtask

  task automatic test_write_read();
    int lat; logic [7:0] rd; logic aa;
    a_xfer(1'b1, 8'd3, 8'h5A, lat, rd, aa);
    n_cmp++; if (lat != 1 || aa !== 1'b0) begin n_bad++; $display("FAIL wr_ack: latency=%0d after=%b required 1/0", lat, aa); end
    a_xfer(1'b0, 8'd3, 8'h00, lat, rd, aa);
    n_cmp++; if (lat != 1 || aa !== 1'b0) begin n_bad++; $display("FAIL rd_ack: latency=%0d after=%b required 1/0", lat, aa); end
    n_cmp++; if (rd !== 8'h5A) begin n_bad++; $display("FAIL rd_data: got %h required 5a", rd); end
    a_xfer(1'b1, 8'd4, 8'h77, lat, rd, aa);
    n_cmp++; if (a_rdata !== 8'h5A) begin n_bad++; $display("FAIL rdata_hold_on_write: got %h required 5a", a_rdata); end
    a_xfer(1'b0, 8'd4, 8'h00, lat, rd, aa);
    n_cmp++; if (rd !== 8'h77) begin n_bad++; $display("FAIL rd_data_2: got %h required 77", rd); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [7:0] rd; logic aa;
    a_xfer(1'b1, 8'd199, 8'h11, lat, rd, aa);
    a_xfer(1'b1, 8'd250, 8'hFF, lat, rd, aa);
    n_cmp++; if (lat != 1 || aa !== 1'b0) begin n_bad++; $display("FAIL oor_wr_ack: latency=%0d after=%b required 1/0", lat, aa); end
    a_xfer(1'b0, 8'd250, 8'h00, lat, rd, aa);
    n_cmp++; if (lat != 1 || rd !== 8'h00) begin n_bad++; $display("FAIL oor_rd: latency=%0d data=%h required 1/00", lat, rd); end
    a_xfer(1'b0, 8'd199, 8'h00, lat, rd, aa);
    n_cmp++; if (rd !== 8'h11) begin n_bad++; $display("FAIL oor_neighbour: got %h required 11", rd); end
  endtask

  task automatic test_wait_states();
    int lat; logic [7:0] rd; logic aa;
    int acks; int pos [3];
    b_xfer(1'b1, 8'd10, 8'h3C, lat, rd, aa);
    n_cmp++; if (lat != 4 || aa !== 1'b0) begin n_bad++; $display("FAIL ws_wr_ack: latency=%0d after=%b required 4/0", lat, aa); end
    b_xfer(1'b0, 8'd10, 8'h00, lat, rd, aa);
    n_cmp++; if (lat != 4 || rd !== 8'h3C) begin n_bad++; $display("FAIL ws_rd: latency=%0d data=%h required 4/3c", lat, rd); end
    b_req = 1'b1; b_dir = 1'b0; b_addr = 8'd10;
    acks = 0; pos[0] = 0; pos[1] = 0; pos[2] = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (b_ack === 1'b1) begin
        if (acks < 3) pos[acks] = i;
        acks++;
      end
    end
    b_req = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (acks != 3) begin n_bad++; $display("FAIL b2b_count: got %0d acks required 3", acks); end
    n_cmp++; if (pos[0] != 4 || pos[1] != 9 || pos[2] != 14) begin n_bad++; $display("FAIL b2b_spacing: got %0d,%0d,%0d required 4,9,14", pos[0], pos[1], pos[2]); end
  endtask

  task automatic test_rst_in_wait();
    int lat; logic [7:0] rd; logic aa; int acks; int waited;
    b_req = 1'b1; b_dir = 1'b0; b_addr = 8'd10;
    @(negedge clk);
    n_cmp++; if (b_rdata !== 8'h3C) begin n_bad++; $display("FAIL rdata_in_wait: got %h required 3c", b_rdata); end
    b_rst = 1'b1; b_req = 1'b0;
    @(negedge clk);
    b_rst = 1'b0;
    n_cmp++; if (b_rdata !== 8'h00 || b_ack !== 1'b0) begin n_bad++; $display("FAIL rst_in_wait: rdata=%h ack=%b required 00/0", b_rdata, b_ack); end
    acks = 0; waited = 0;
    while ((b_busy !== 1'b0 || waited < 6) && waited < 200) begin
      @(negedge clk); waited++;
      if (b_ack === 1'b1) acks++;
    end
    n_cmp++; if (acks != 0) begin n_bad++; $display("FAIL rst_no_ack: got %0d acks required 0", acks); end
    b_xfer(1'b0, 8'd10, 8'h00, lat, rd, aa);
    n_cmp++; if (lat != 4 || rd !== (CLR ? 8'h00 : 8'h3C)) begin n_bad++; $display("FAIL post_rst_rd: latency=%0d data=%h required 4/%h", lat, rd, CLR ? 8'h00 : 8'h3C); end
  endtask

  task automatic test_drop_in_wait();
    int lat; logic [7:0] rd; logic aa; int acks; int first;
    b_req = 1'b1; b_dir = 1'b1; b_addr = 8'd7; b_wdata = 8'h11;
    @(negedge clk);
    b_req = 1'b0;
    acks = 0; first = 0;
    for (int i = 2; i <= 9; i++) begin
      @(negedge clk);
      if (b_ack === 1'b1) begin acks++; if (first == 0) first = i; end
    end
    n_cmp++; if (acks != 1 || first != 4) begin n_bad++; $display("FAIL drop_ack: acks=%0d at=%0d required 1 at 4", acks, first); end
    b_xfer(1'b0, 8'd7, 8'h00, lat, rd, aa);
    n_cmp++; if (rd !== 8'h11) begin n_bad++; $display("FAIL drop_rd: got %h required 11", rd); end
  endtask

`ifdef D_MEM_CLEAR_EN
  task automatic test_clear();
    int lat; logic [7:0] rd; logic aa; int busy_cnt; int ack_busy; int ack_at; logic [7:0] ack_data;
    for (int i = 0; i < 64; i++) b_xfer(1'b1, 8'(i), 8'hAA, lat, rd, aa);
    b_xfer(1'b0, 8'd5, 8'h00, lat, rd, aa);
    n_cmp++; if (rd !== 8'hAA) begin n_bad++; $display("FAIL clr_fill: got %h required aa", rd); end
    b_rst = 1'b1; b_req = 1'b1; b_dir = 1'b0; b_addr = 8'd5;
    @(negedge clk);
    b_rst = 1'b0;
    busy_cnt = 0; ack_busy = 0; ack_at = 0; ack_data = 8'hEE;
    for (int i = 1; i <= 200; i++) begin
      if (b_busy === 1'b1) busy_cnt++;
      if (b_ack === 1'b1) begin
        if (b_busy === 1'b1) ack_busy++;
        ack_at = i; ack_data = b_rdata; break;
      end
      @(negedge clk);
    end
    b_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy_cnt != 64) begin n_bad++; $display("FAIL clr_busy_len: got %0d required 64", busy_cnt); end
    n_cmp++; if (ack_busy != 0 || ack_at != 69) begin n_bad++; $display("FAIL clr_held_req: ack_at=%0d during_busy=%0d required 69/0", ack_at, ack_busy); end
    n_cmp++; if (ack_data !== 8'h00) begin n_bad++; $display("FAIL clr_rd5: got %h required 00", ack_data); end
    b_xfer(1'b0, 8'd0, 8'h00, lat, rd, aa);
    n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL clr_rd0: got %h required 00", rd); end
    b_xfer(1'b0, 8'd63, 8'h00, lat, rd, aa);
    n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL clr_rd63: got %h required 00", rd); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_wait_states();
    test_rst_in_wait();
    test_drop_in_wait();
`ifdef D_MEM_CLEAR_EN
    test_clear();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
